painterengine_gpu_reader: RTL

//  AXI4 burst-read DMA engine that feeds the GPU display pipeline with 32-bit RGBA words.

---
 rtl/painterengine_gpu_reader_pkg.sv | 27 ++
 rtl/painterengine_gpu_reader_burstcalc.sv | 23 ++
 rtl/painterengine_gpu_reader.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/painterengine_gpu_reader_pkg.sv
// rtl/painterengine_gpu_reader_pkg.sv - shared AXI constants, reader state encodings and helpers
package painterengine_gpu_reader_pkg;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] SIZE_4B    = 3'b010;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  localparam logic [2:0] READER_STATE_IDLE  = 3'd0;
  localparam logic [2:0] READER_STATE_CALC  = 3'd1;
  localparam logic [2:0] READER_STATE_ADDR  = 3'd2;
  localparam logic [2:0] READER_STATE_DATA  = 3'd3;
  localparam logic [2:0] READER_STATE_DRAIN = 3'd4;
  localparam logic [2:0] READER_STATE_DONE  = 3'd5;
  localparam logic [2:0] READER_STATE_ERROR = 3'd6;

  // Smallest of the three burst limits; the result never exceeds 256, so 9 bits suffice.
  function automatic logic [8:0] clamp_beats(input logic [31:0] remaining,
                                             input logic [31:0] max_beats,
                                             input logic [31:0] to_boundary);
    logic [31:0] m;
    m = remaining;
    if (max_beats < m) m = max_beats;
    if (to_boundary < m) m = to_boundary;
    return 9'(m);
  endfunction

endpackage

// File: rtl/painterengine_gpu_reader_burstcalc.sv
// rtl/painterengine_gpu_reader_burstcalc.sv - beats for the next burst from address and words left
module painterengine_gpu_reader_burstcalc
  import painterengine_gpu_reader_pkg::*;
#(
  parameter int MAX_BURST_LEN  = 16,
  parameter int BOUNDARY_BYTES = 4096
) (
  input  logic [31:0] cur_addr,
  input  logic [31:0] remaining,
  output logic [8:0]  beats
);

  localparam logic [31:0] MAX_BEATS = 32'(MAX_BURST_LEN);
  localparam logic [31:0] BOUNDARY  = 32'(BOUNDARY_BYTES);

  logic [31:0] to_boundary;

  always_comb begin
    to_boundary = (BOUNDARY - (cur_addr & (BOUNDARY - 32'd1))) >> 2;
    beats       = clamp_beats(remaining, MAX_BEATS, to_boundary);
  end

endmodule

// File: rtl/painterengine_gpu_reader.sv
// rtl/painterengine_gpu_reader.sv - AXI4 burst-read DMA streaming RGBA words to the display pipeline
module painterengine_gpu_reader
  import painterengine_gpu_reader_pkg::*;
#(
  parameter int MAX_BURST_LEN  = 16,
  parameter int BOUNDARY_BYTES = 4096
) (
  input  logic        i_wire_clock,
  input  logic        i_wire_resetn,
  input  logic [31:0] i_wire_address,
  input  logic [31:0] i_wire_length,
  output logic        o_wire_done,
  output logic        o_wire_error,
  output logic [31:0] o_wire_data,
  output logic        o_wire_data_valid,
  input  logic        i_wire_data_next,
  output logic [31:0] o_wire_m_axi_araddr,
  output logic [7:0]  o_wire_m_axi_arlen,
  output logic [2:0]  o_wire_m_axi_arsize,
  output logic [1:0]  o_wire_m_axi_arburst,
  output logic        o_wire_m_axi_arvalid,
  input  logic        i_wire_m_axi_arready,
  input  logic [31:0] i_wire_m_axi_rdata,
  input  logic [1:0]  i_wire_m_axi_rresp,
  input  logic        i_wire_m_axi_rlast,
  input  logic        i_wire_m_axi_rvalid,
  output logic        o_wire_m_axi_rready
);

  logic [2:0]  state;
  logic [31:0] cur_addr;
  logic [31:0] remaining;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic        arvalid;
  logic        done;
  logic        error;

  logic [8:0]  beats;
  logic [8:0]  issued_beats;
  logic        in_data;
  logic        in_drain;
  logic        rready;
  logic        r_hs;
  logic        resp_ok;

  painterengine_gpu_reader_burstcalc #(
    .MAX_BURST_LEN (MAX_BURST_LEN),
    .BOUNDARY_BYTES(BOUNDARY_BYTES)
  ) u_burstcalc (
    .cur_addr (cur_addr),
    .remaining(remaining),
    .beats    (beats)
  );

  // The consumer's next doubles as rready, so a word is only ever presented when it can be taken.
  always_comb begin
    in_data      = (state == READER_STATE_DATA);
    in_drain     = (state == READER_STATE_DRAIN);
    rready       = in_drain | (in_data & i_wire_data_next);
    r_hs         = i_wire_m_axi_rvalid & rready;
    resp_ok      = (i_wire_m_axi_rresp == RESP_OKAY);
    issued_beats = {1'b0, arlen} + 9'd1;
  end

  assign o_wire_done          = done;
  assign o_wire_error         = error;
  assign o_wire_data          = i_wire_m_axi_rdata;
  assign o_wire_data_valid    = in_data & r_hs & resp_ok;
  assign o_wire_m_axi_araddr  = araddr;
  assign o_wire_m_axi_arlen   = arlen;
  assign o_wire_m_axi_arsize  = SIZE_4B;
  assign o_wire_m_axi_arburst = BURST_INCR;
  assign o_wire_m_axi_arvalid = arvalid;
  assign o_wire_m_axi_rready  = rready;

  always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
    if (!i_wire_resetn) begin
      state     <= READER_STATE_IDLE;
      cur_addr  <= 32'd0;
      remaining <= 32'd0;
      araddr    <= 32'd0;
      arlen     <= 8'd0;
      arvalid   <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      case (state)
        READER_STATE_IDLE: begin
          cur_addr  <= i_wire_address;
          remaining <= i_wire_length;
          if (i_wire_length == 32'd0) begin
            state <= READER_STATE_DONE;
            done  <= 1'b1;
          end else if (i_wire_address[1:0] != 2'b00) begin
            state <= READER_STATE_ERROR;
            error <= 1'b1;
          end else begin
            state <= READER_STATE_CALC;
          end
        end
        READER_STATE_CALC: begin
          araddr  <= cur_addr;
          arlen   <= 8'(beats - 9'd1);
          arvalid <= 1'b1;
          state   <= READER_STATE_ADDR;
        end
        READER_STATE_ADDR: begin
          if (i_wire_m_axi_arready) begin
            arvalid   <= 1'b0;
            cur_addr  <= cur_addr + {21'd0, issued_beats, 2'b00};
            remaining <= remaining - {23'd0, issued_beats};
            state     <= READER_STATE_DATA;
          end
        end
        READER_STATE_DATA: begin
          if (r_hs) begin
            if (!resp_ok) begin
              if (i_wire_m_axi_rlast) begin
                state <= READER_STATE_ERROR;
                error <= 1'b1;
              end else begin
                state <= READER_STATE_DRAIN;
              end
            end else if (i_wire_m_axi_rlast) begin
              if (remaining == 32'd0) begin
                state <= READER_STATE_DONE;
                done  <= 1'b1;
              end else begin
                state <= READER_STATE_CALC;
              end
            end
          end
        end
        READER_STATE_DRAIN: begin
          if (i_wire_m_axi_rvalid && i_wire_m_axi_rlast) begin
            state <= READER_STATE_ERROR;
            error <= 1'b1;
          end
        end
        READER_STATE_DONE:  state <= READER_STATE_DONE;
        READER_STATE_ERROR: state <= READER_STATE_ERROR;
        default:            state <= READER_STATE_IDLE;
      endcase
    end
  end

endmodule
